pwm_sample_engine: RTL

- Waveform stage directly downstream of the PWM register/sample-FIFO block.
- Pops 8- or 16-bit samples from that block's FIFO and generates a fixed-period PWM output whose duty is set by each sample.
- Flags FIFO underflow as a sticky interrupt.
- Configuration comes straight from the control CSR: reload[31:2], sample width, enable.

---
 rtl/pwm_sample_engine.sv | 99 +++++++++
 1 files changed

// File: rtl/pwm_sample_engine.sv
// pwm_sample_engine: pops 8/16-bit duty samples from a FWFT FIFO and emits a fixed-period PWM.
// Ports: pwm_clock_i/pwm_reset_i (async active-high), cfg_enable_i/cfg_16bit_i/cfg_reload_i from CSR,
// fifo_empty_i/fifo_data_i/fifo_pop_o to the sample FIFO, underflow_clr_i clears the sticky flag,
// pwm_o registered output, period_o boundary pulse, underflow_o sticky flag, int_o gated interrupt.
// Option: define PWM_POLARITY_EN to add cfg_invert_i, which inverts the active-level of pwm_o.
module pwm_sample_engine #(
    parameter int CW = 30,
    parameter int SW = 16
) (
    input  logic          pwm_clock_i,
    input  logic          pwm_reset_i,
    input  logic          cfg_enable_i,
    input  logic          cfg_16bit_i,
    input  logic [CW-1:0] cfg_reload_i,
`ifdef PWM_POLARITY_EN
    input  logic          cfg_invert_i,
`endif
    input  logic          fifo_empty_i,
    input  logic [7:0]    fifo_data_i,
    output logic          fifo_pop_o,
    input  logic          underflow_clr_i,
    output logic          pwm_o,
    output logic          period_o,
    output logic          underflow_o,
    output logic          int_o
);
    typedef enum logic {S_LO, S_HI} state_t;
    state_t        r_state, w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_duty, r_staged, w_staged_nxt;
    logic          r_staged_valid;
    logic [7:0]    r_lo;
    logic          w_wrap, w_cmp, w_pwm_nxt, w_fetch, w_complete, w_load;
    always_comb begin
        w_wrap       = r_cnt >= cfg_reload_i;
        w_cmp        = r_cnt < CW'(r_duty);
        w_fetch      = cfg_enable_i && !r_staged_valid && !fifo_empty_i;
        // S_HI always completes the pair, even if the width mode changed meanwhile
        w_complete   = w_fetch && (r_state == S_HI || !cfg_16bit_i);
        w_state_nxt  = w_fetch ? (w_complete ? S_LO : S_HI) : r_state;
        w_staged_nxt = (r_state == S_HI) ? SW'({fifo_data_i, r_lo}) : SW'(fifo_data_i);
        w_load       = w_wrap && r_staged_valid;
        fifo_pop_o   = w_fetch;
        int_o        = underflow_o && cfg_enable_i;
`ifdef PWM_POLARITY_EN
        w_pwm_nxt    = w_cmp ^ cfg_invert_i;
`else
        w_pwm_nxt    = w_cmp;
`endif
    end
    always_ff @(posedge pwm_clock_i or posedge pwm_reset_i) begin
        if (pwm_reset_i)
            r_state <= S_LO;
        else
            r_state <= cfg_enable_i ? w_state_nxt : S_LO;
    end
    always_ff @(posedge pwm_clock_i or posedge pwm_reset_i) begin
        if (pwm_reset_i) begin
            r_cnt          <= '0;
            r_duty         <= '0;
            r_staged       <= '0;
            r_staged_valid <= 1'b0;
            r_lo           <= '0;
            pwm_o          <= 1'b0;
            period_o       <= 1'b0;
            underflow_o    <= 1'b0;
        end else begin
            if (!cfg_enable_i) begin
                r_cnt          <= '0;
                r_duty         <= '0;
                r_staged       <= '0;
                r_staged_valid <= 1'b0;
                r_lo           <= '0;
                pwm_o          <= 1'b0;
                period_o       <= 1'b0;
            end else begin
                r_cnt    <= w_wrap ? '0 : r_cnt + CW'(1);
                period_o <= w_wrap;
                pwm_o    <= w_pwm_nxt;
                if (w_fetch && !w_complete)
                    r_lo <= fifo_data_i;
                // fetch and consume are exclusive: fetch needs staged_valid=0, consume needs 1
                if (w_complete) begin
                    r_staged       <= w_staged_nxt;
                    r_staged_valid <= 1'b1;
                end else if (w_load) begin
                    r_staged_valid <= 1'b0;
                end
                if (w_load)
                    r_duty <= r_staged;
            end
            // set has priority over a coincident clear
            if (cfg_enable_i && w_wrap && !r_staged_valid)
                underflow_o <= 1'b1;
            else if (underflow_clr_i)
                underflow_o <= 1'b0;
        end
    end
endmodule
